// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the icache and dcache.
// Each granted refill is a 4-beat INCR burst assembled into a 128-bit line.
module cache_rd_arbiter #(
    parameter logic [3:0] ICACHE_ID = 4'd0,
    parameter logic [3:0] DCACHE_ID = 4'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   icache_ren,
    input  logic [31:0]  icache_raddr,
    input  logic         icache_flush,
    output logic         icache_rrdy,
    output logic         icache_rvalid,
    output logic [127:0] icache_rdata,
    input  logic [3:0]   dcache_ren,
    input  logic [31:0]  dcache_raddr,
    output logic         dcache_rrdy,
    output logic         dcache_rvalid,
    output logic [127:0] dcache_rdata,
    output logic         arvalid,
    input  logic         arready,
    output logic [31:0]  araddr,
    output logic [3:0]   arid,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    input  logic         rvalid,
    output logic         rready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    output logic         bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;

    state_t       state;
    grant_t       grant;
    grant_t       last_grant;
    logic         i_pend;
    logic         d_pend;
    logic         kill;
    logic [1:0]   beat;
    logic [27:0]  i_line_addr;
    logic [27:0]  d_line_addr;
    logic [127:0] line;
    logic [127:0] i_rdata_q;
    logic [127:0] d_rdata_q;

    logic i_req;
    logic win_i;
    logic win_d;
    logic i_capture;
    logic d_capture;
    logic i_deliver;
    logic d_deliver;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{icache_raddr[3:0], dcache_raddr[3:0]};

    assign arlen   = 8'd3;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arid    = (grant == GNT_D) ? DCACHE_ID : ICACHE_ID;

    // A flush in the same cycle hides a pending icache request from arbitration.
    always_comb begin
        icache_rrdy   = !i_pend && !(state != S_IDLE && grant == GNT_I);
        dcache_rrdy   = !d_pend && !(state != S_IDLE && grant == GNT_D);
        i_capture     = (icache_ren != 4'd0) && icache_rrdy && !icache_flush;
        d_capture     = (dcache_ren != 4'd0) && dcache_rrdy;
        i_req         = i_pend && !icache_flush;
        win_d         = (state == S_IDLE) && d_pend && (!i_req || last_grant == GNT_I);
        win_i         = (state == S_IDLE) && i_req && !win_d;
        i_deliver     = (state == S_DONE) && (grant == GNT_I) && !kill && !icache_flush;
        d_deliver     = (state == S_DONE) && (grant == GNT_D);
        icache_rvalid = i_deliver;
        dcache_rvalid = d_deliver;
        icache_rdata  = i_deliver ? line : i_rdata_q;
        dcache_rdata  = d_deliver ? line : d_rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_pend      <= 1'b0;
            d_pend      <= 1'b0;
            i_line_addr <= 28'd0;
            d_line_addr <= 28'd0;
        end else begin
            if (i_capture) begin
                i_pend      <= 1'b1;
                i_line_addr <= icache_raddr[31:4];
            end else if (icache_flush || win_i) begin
                i_pend <= 1'b0;
            end
            if (d_capture) begin
                d_pend      <= 1'b1;
                d_line_addr <= dcache_raddr[31:4];
            end else if (win_d) begin
                d_pend <= 1'b0;
            end
        end
    end

    // The DONE branch clears kill after any flush-driven set earlier in this block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            grant      <= GNT_I;
            last_grant <= GNT_I;
            kill       <= 1'b0;
            beat       <= 2'd0;
            line       <= 128'd0;
            i_rdata_q  <= 128'd0;
            d_rdata_q  <= 128'd0;
            arvalid    <= 1'b0;
            araddr     <= 32'd0;
            rready     <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (icache_flush && grant == GNT_I && state != S_IDLE)
                kill <= 1'b1;
            if (i_deliver)
                i_rdata_q <= line;
            if (d_deliver)
                d_rdata_q <= line;
            case (state)
                S_IDLE: begin
                    if (win_d) begin
                        grant      <= GNT_D;
                        last_grant <= GNT_D;
                        araddr     <= {d_line_addr, 4'b0000};
                        arvalid    <= 1'b1;
                        state      <= S_AR;
                    end else if (win_i) begin
                        grant      <= GNT_I;
                        last_grant <= GNT_I;
                        araddr     <= {i_line_addr, 4'b0000};
                        arvalid    <= 1'b1;
                        state      <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        beat    <= 2'd0;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        line[{beat, 5'd0} +: 32] <= rdata;
                        if (rresp != 2'b00 || rlast != (beat == 2'd3))
                            bus_err <= 1'b1;
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            rready <= 1'b0;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    kill  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter: scripted AXI slave, delivery monitor, hand-computed lines.
module tb_cache_rd_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   icache_ren = 4'd0;
    logic [31:0]  icache_raddr = 32'd0;
    logic         icache_flush = 1'b0;
    logic         icache_rrdy;
    logic         icache_rvalid;
    logic [127:0] icache_rdata;
    logic [3:0]   dcache_ren = 4'd0;
    logic [31:0]  dcache_raddr = 32'd0;
    logic         dcache_rrdy;
    logic         dcache_rvalid;
    logic [127:0] dcache_rdata;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [31:0]  araddr;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [31:0]  rdata = 32'd0;
    logic [1:0]   rresp = 2'b00;
    logic         rlast = 1'b0;
    logic         bus_err;

    always #5 clk = ~clk;

    cache_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_ren(icache_ren), .icache_raddr(icache_raddr), .icache_flush(icache_flush),
        .icache_rrdy(icache_rrdy), .icache_rvalid(icache_rvalid), .icache_rdata(icache_rdata),
        .dcache_ren(dcache_ren), .dcache_raddr(dcache_raddr),
        .dcache_rrdy(dcache_rrdy), .dcache_rvalid(dcache_rvalid), .dcache_rdata(dcache_rdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .bus_err(bus_err)
    );

    int vecCount = 0;
    int errCount = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave behaviour knobs; beat data gets arid placed in the top nibble.
    logic [31:0] cfgBeat [4];
    int          cfgArStall = 0;
    int          cfgGap = 0;
    int          cfgErrBeat = -1;
    int          cfgLastBeat = 3;
    logic [1:0]  cfgErrResp = 2'b00;

    int          sState = 0;
    int          sStall = 0;
    int          sBeat = 0;
    int          sGap = 0;
    int          sAccepted = 0;
    int          arCount = 0;
    int          arUnstable = 0;
    logic        rreadyAtDrive = 1'b0;
    logic        sawAr = 1'b0;
    logic [31:0] firstAddr = 32'd0;
    logic [31:0] arAddrSeen = 32'd0;
    logic [3:0]  arIdSeen = 4'd0;
    logic [3:0]  arIdLog [16];

    always @(negedge clk) begin
        if (!rst) begin
            sState = 0; sStall = 0; sBeat = 0; sGap = 0; sawAr = 1'b0;
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0;
        end else if (sState == 0) begin
            arready = 1'b0;
            if (arvalid) begin
                if (!sawAr) begin
                    sawAr = 1'b1;
                    firstAddr = araddr;
                end else if (araddr !== firstAddr) begin
                    arUnstable++;
                end
                if (sStall < cfgArStall) begin
                    sStall++;
                end else begin
                    arready = 1'b1;
                    arAddrSeen = araddr;
                    arIdSeen = arid;
                    if (arCount < 16) arIdLog[arCount] = arid;
                    arCount++;
                    sState = 1;
                end
            end else if (sawAr) begin
                arUnstable++;
            end
        end else begin
            if (sState == 1) begin
                arready = 1'b0; sState = 2; sBeat = 0; sGap = 0; sStall = 0;
                sawAr = 1'b0; rvalid = 1'b0;
            end
            if (rvalid && rreadyAtDrive) begin
                sBeat++; sGap = 0; sAccepted++;
            end
            if (sBeat == 4) begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; sState = 0;
            end else if (sBeat > 0 && sGap < cfgGap) begin
                rvalid = 1'b0; rlast = 1'b0; sGap++;
            end else begin
                rvalid = 1'b1;
                rdata = cfgBeat[sBeat] + {arIdSeen, 28'h0};
                rresp = (sBeat == cfgErrBeat) ? cfgErrResp : 2'b00;
                rlast = (sBeat == cfgLastBeat);
                rreadyAtDrive = rready;
            end
        end
    end

    int           iDelivCnt = 0;
    int           dDelivCnt = 0;
    int           iDelivCyc = 0;
    int           dDelivCyc = 0;
    logic [127:0] iDelivData = 128'd0;
    logic [127:0] dDelivData = 128'd0;

    always begin
        @(negedge clk);
        #2;
        if (icache_rvalid) begin
            iDelivCnt++; iDelivCyc = cyc; iDelivData = icache_rdata;
        end
        if (dcache_rvalid) begin
            dDelivCnt++; dDelivCyc = cyc; dDelivData = dcache_rdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit toData, input logic [31:0] addr, output int startCyc);
        @(negedge clk);
        if (toData) begin
            dcache_ren = 4'hF; dcache_raddr = addr;
        end else begin
            icache_ren = 4'hF; icache_raddr = addr;
        end
        startCyc = cyc;
        @(negedge clk);
        icache_ren = 4'd0;
        dcache_ren = 4'd0;
    endtask

    task automatic waitDeliv(input bit isData, input int target, input int budget, input string tag);
        int n = 0;
        while (((isData ? dDelivCnt : iDelivCnt) < target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 128'((isData ? dDelivCnt : iDelivCnt) >= target), 128'd1);
    endtask

    task automatic setBeats(input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3);
        cfgBeat[0] = b0; cfgBeat[1] = b1; cfgBeat[2] = b2; cfgBeat[3] = b3;
    endtask

    initial begin
        int start;
        int arBase;
        int acc0;

        setBeats(32'h11, 32'h22, 32'h33, 32'h44);
        repeat (2) @(negedge clk);
        checkOutput("rst_arvalid", 128'(arvalid), 128'd0);
        checkOutput("rst_rready", 128'(rready), 128'd0);
        checkOutput("rst_araddr", 128'(araddr), 128'd0);
        checkOutput("rst_i_rrdy", 128'(icache_rrdy), 128'd1);
        checkOutput("rst_d_rrdy", 128'(dcache_rrdy), 128'd1);
        checkOutput("rst_i_rvalid", 128'(icache_rvalid), 128'd0);
        checkOutput("rst_i_rdata", icache_rdata, 128'd0);
        checkOutput("rst_bus_err", 128'(bus_err), 128'd0);
        rst = 1'b1;

        // Single icache refill with zero wait states.
        applyStimulus(1'b0, 32'h1C00_0124, start);
        checkOutput("t1_i_rrdy_busy", 128'(icache_rrdy), 128'd0);
        waitDeliv(1'b0, 1, 40, "t1_done");
        checkOutput("t1_araddr", 128'(arAddrSeen), 128'h1C00_0120);
        checkOutput("t1_arid", 128'(arIdSeen), 128'd0);
        checkOutput("t1_arlen", 128'(arlen), 128'd3);
        checkOutput("t1_arsize", 128'(arsize), 128'd2);
        checkOutput("t1_arburst", 128'(arburst), 128'd1);
        checkOutput("t1_latency", 128'(iDelivCyc - start), 128'd7);
        checkOutput("t1_line", iDelivData, 128'h00000044_00000033_00000022_00000011);
        checkOutput("t1_no_d_deliv", 128'(dDelivCnt), 128'd0);
        checkOutput("t1_rdata_held", icache_rdata, 128'h00000044_00000033_00000022_00000011);

        // Simultaneous requests: dcache wins the tie, icache follows immediately.
        setBeats(32'h1, 32'h2, 32'h3, 32'h4);
        @(negedge clk);
        icache_ren = 4'hF; icache_raddr = 32'h0000_2040;
        dcache_ren = 4'hF; dcache_raddr = 32'h0000_3088;
        start = cyc;
        arBase = arCount;
        @(negedge clk);
        icache_ren = 4'd0; dcache_ren = 4'd0;
        waitDeliv(1'b0, 2, 60, "t2_i_done");
        checkOutput("t2_first_arid", 128'(arIdLog[arBase]), 128'd1);
        checkOutput("t2_second_arid", 128'(arIdLog[arBase + 1]), 128'd0);
        checkOutput("t2_d_count", 128'(dDelivCnt), 128'd1);
        checkOutput("t2_d_latency", 128'(dDelivCyc - start), 128'd7);
        checkOutput("t2_i_follow", 128'(iDelivCyc - dDelivCyc), 128'd7);
        checkOutput("t2_d_line", dDelivData, 128'h10000004_10000003_10000002_10000001);
        checkOutput("t2_i_line", iDelivData, 128'h00000004_00000003_00000002_00000001);
        checkOutput("t2_i_araddr", 128'(arAddrSeen), 128'h0000_2040);

        // Flush during beat 2 kills icache delivery but the burst still drains.
        setBeats(32'h100, 32'h200, 32'h300, 32'h400);
        acc0 = sAccepted;
        applyStimulus(1'b0, 32'h0000_5000, start);
        repeat (4) @(negedge clk);
        checkOutput("t3_rready_beat2", 128'(rready), 128'd1);
        icache_flush = 1'b1;
        @(negedge clk);
        icache_flush = 1'b0;
        checkOutput("t3_d_rrdy", 128'(dcache_rrdy), 128'd1);
        dcache_ren = 4'hF; dcache_raddr = 32'h0000_6000;
        @(negedge clk);
        dcache_ren = 4'd0;
        waitDeliv(1'b1, 2, 40, "t3_d_done");
        checkOutput("t3_i_killed", 128'(iDelivCnt), 128'd2);
        checkOutput("t3_beats_accepted", 128'(sAccepted - acc0), 128'd8);
        checkOutput("t3_d_arid", 128'(arIdSeen), 128'd1);
        checkOutput("t3_d_araddr", 128'(arAddrSeen), 128'h0000_6000);
        checkOutput("t3_d_line", dDelivData, 128'h10000400_10000300_10000200_10000100);

        // Flush together with ren: nothing is captured.
        @(negedge clk);
        icache_ren = 4'hF; icache_raddr = 32'h0000_7000; icache_flush = 1'b1;
        arBase = arCount;
        @(negedge clk);
        icache_ren = 4'd0; icache_flush = 1'b0;
        checkOutput("t4_i_rrdy", 128'(icache_rrdy), 128'd1);
        checkOutput("t4_arvalid_now", 128'(arvalid), 128'd0);
        repeat (5) @(negedge clk);
        checkOutput("t4_arvalid_later", 128'(arvalid), 128'd0);
        checkOutput("t4_no_ar", 128'(arCount - arBase), 128'd0);

        // AR stall of 5 cycles plus 2-cycle gaps between beats.
        setBeats(32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004);
        cfgArStall = 5; cfgGap = 2;
        applyStimulus(1'b0, 32'h8000_00F8, start);
        repeat (3) @(negedge clk);
        checkOutput("t5_arvalid_stall", 128'(arvalid), 128'd1);
        checkOutput("t5_araddr_stall", 128'(araddr), 128'h8000_00F0);
        waitDeliv(1'b0, 3, 80, "t5_done");
        checkOutput("t5_latency", 128'(iDelivCyc - start), 128'd18);
        checkOutput("t5_line", iDelivData, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001);
        checkOutput("t5_ar_stable", 128'(arUnstable), 128'd0);
        checkOutput("t5_araddr", 128'(arAddrSeen), 128'h8000_00F0);
        cfgArStall = 0; cfgGap = 0;

        // SLVERR on beat 1 and rlast on beat 2: sticky bus_err, one delivery.
        checkOutput("t6_err_before", 128'(bus_err), 128'd0);
        setBeats(32'hA, 32'hB, 32'hC, 32'hD);
        cfgErrBeat = 1; cfgErrResp = 2'b10; cfgLastBeat = 2;
        applyStimulus(1'b1, 32'h9000_0010, start);
        waitDeliv(1'b1, 3, 40, "t6_done");
        checkOutput("t6_bus_err", 128'(bus_err), 128'd1);
        checkOutput("t6_d_line", dDelivData, 128'h1000000D_1000000C_1000000B_1000000A);
        repeat (6) @(negedge clk);
        checkOutput("t6_single_pulse", 128'(dDelivCnt), 128'd3);
        checkOutput("t6_err_sticky", 128'(bus_err), 128'd1);
        cfgErrBeat = -1; cfgErrResp = 2'b00; cfgLastBeat = 3;

        // Asynchronous reset in the middle of the R phase.
        setBeats(32'h5, 32'h6, 32'h7, 32'h8);
        applyStimulus(1'b0, 32'hA000_0000, start);
        repeat (3) @(negedge clk);
        checkOutput("t7_in_r", 128'(rready), 128'd1);
        rst = 1'b0;
        #1;
        checkOutput("t7_arvalid", 128'(arvalid), 128'd0);
        checkOutput("t7_rready", 128'(rready), 128'd0);
        checkOutput("t7_araddr", 128'(araddr), 128'd0);
        checkOutput("t7_i_rdata", icache_rdata, 128'd0);
        checkOutput("t7_d_rdata", dcache_rdata, 128'd0);
        checkOutput("t7_bus_err", 128'(bus_err), 128'd0);
        checkOutput("t7_i_rrdy", 128'(icache_rrdy), 128'd1);
        checkOutput("t7_d_rrdy", 128'(dcache_rrdy), 128'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t7_i_rrdy_after", 128'(icache_rrdy), 128'd1);
        checkOutput("t7_d_rrdy_after", 128'(dcache_rrdy), 128'd1);
        checkOutput("t7_arvalid_after", 128'(arvalid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
